// File: rtl/reservation_station.sv
// Tomasulo reservation station: buffers issued ops, wakes operands from the ALU/load
// broadcasts and dispatches the lowest ready entry. RS_ISSUE_BYPASS_EN enables issue-to-ALU bypass.
module reservation_station #(
  parameter int RS_SIZE   = 16,
  parameter int ROB_POS_W = 5,
  parameter int DATA_W    = 32,
  parameter int OPENUM_W  = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 clr,
  input  logic                 rs_enable,
  input  logic [OPENUM_W-1:0]  issue_openum,
  input  logic [DATA_W-1:0]    issue_rs1_val,
  input  logic [DATA_W-1:0]    issue_rs2_val,
  input  logic [ROB_POS_W-1:0] issue_rs1_rob_pos,
  input  logic [ROB_POS_W-1:0] issue_rs2_rob_pos,
  input  logic [DATA_W-1:0]    issue_imm,
  input  logic [DATA_W-1:0]    issue_pc,
  input  logic                 issue_pred_jump,
  input  logic [ROB_POS_W-1:0] issue_rob_pos,
  input  logic                 alu_result_ready,
  input  logic [ROB_POS_W-1:0] alu_result_rob_pos,
  input  logic [DATA_W-1:0]    alu_result_val,
  input  logic                 lsb_load_result_ready,
  input  logic [ROB_POS_W-1:0] lsb_load_result_rob_pos,
  input  logic [DATA_W-1:0]    lsb_load_result_val,
  output logic                 rs_full,
  output logic                 alu_enable,
  output logic [OPENUM_W-1:0]  alu_openum,
  output logic [DATA_W-1:0]    alu_rs1_val,
  output logic [DATA_W-1:0]    alu_rs2_val,
  output logic [DATA_W-1:0]    alu_imm,
  output logic [DATA_W-1:0]    alu_pc,
  output logic                 alu_pred_jump,
  output logic [ROB_POS_W-1:0] alu_rob_pos
);
  localparam int IDX_W = $clog2(RS_SIZE);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RS_SIZE);
  localparam logic [CNT_W-1:0] HIGH_CNT = CNT_W'(RS_SIZE - 1);

  logic [RS_SIZE-1:0]   r_busy;
  logic [OPENUM_W-1:0]  r_op   [RS_SIZE];
  logic [DATA_W-1:0]    r_v1   [RS_SIZE];
  logic [DATA_W-1:0]    r_v2   [RS_SIZE];
  logic [ROB_POS_W-1:0] r_q1   [RS_SIZE];
  logic [ROB_POS_W-1:0] r_q2   [RS_SIZE];
  logic [DATA_W-1:0]    r_imm  [RS_SIZE];
  logic [DATA_W-1:0]    r_pc   [RS_SIZE];
  logic                 r_pj   [RS_SIZE];
  logic [ROB_POS_W-1:0] r_rob  [RS_SIZE];
  logic [CNT_W-1:0]     r_count;

  logic [RS_SIZE-1:0]   w_ready;
  logic                 w_free_found;
  logic                 w_sel_found;
  logic [IDX_W-1:0]     w_free_idx;
  logic [IDX_W-1:0]     w_sel_idx;
  logic [ROB_POS_W-1:0] w_in_q1;
  logic [ROB_POS_W-1:0] w_in_q2;
  logic [DATA_W-1:0]    w_in_v1;
  logic [DATA_W-1:0]    w_in_v2;
  logic                 w_insert;
  logic                 w_bypass;
  logic                 w_flush;

  // Resolve one operand against both broadcasts; the ALU result wins a double match.
  function automatic logic [ROB_POS_W+DATA_W-1:0] snoop(
    input logic [ROB_POS_W-1:0] q,      input logic [DATA_W-1:0] v,
    input logic                 a_rdy,  input logic [ROB_POS_W-1:0] a_pos,
    input logic [DATA_W-1:0]    a_val,  input logic l_rdy,
    input logic [ROB_POS_W-1:0] l_pos,  input logic [DATA_W-1:0] l_val);
    if (q != '0 && a_rdy && a_pos == q) return {{ROB_POS_W{1'b0}}, a_val};
    if (q != '0 && l_rdy && l_pos == q) return {{ROB_POS_W{1'b0}}, l_val};
    return {q, v};
  endfunction

  always_comb begin
    w_ready      = '0;
    w_free_found = 1'b0;
    w_free_idx   = '0;
    w_sel_found  = 1'b0;
    w_sel_idx    = '0;
    // Descending scan so the lowest index is the last (winning) assignment.
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      w_ready[i] = r_busy[i] && (r_q1[i] == '0) && (r_q2[i] == '0);
      if (!r_busy[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
      if (w_ready[i]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = IDX_W'(i);
      end
    end
    {w_in_q1, w_in_v1} = snoop(issue_rs1_rob_pos, issue_rs1_val, alu_result_ready,
                               alu_result_rob_pos, alu_result_val, lsb_load_result_ready,
                               lsb_load_result_rob_pos, lsb_load_result_val);
    {w_in_q2, w_in_v2} = snoop(issue_rs2_rob_pos, issue_rs2_val, alu_result_ready,
                               alu_result_rob_pos, alu_result_val, lsb_load_result_ready,
                               lsb_load_result_rob_pos, lsb_load_result_val);
  end

`ifdef RS_ISSUE_BYPASS_EN
  assign w_bypass = rs_enable && !w_sel_found && (w_in_q1 == '0) && (w_in_q2 == '0);
`else
  assign w_bypass = 1'b0;
`endif

  assign w_insert = rs_enable && !w_bypass && (r_count < FULL_CNT) && w_free_found;
  assign w_flush  = rst || (rdy && clr);
  assign rs_full  = (r_count >= HIGH_CNT);

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_busy        <= '0;
      r_count       <= '0;
      alu_enable    <= 1'b0;
      alu_openum    <= '0;
      alu_rs1_val   <= '0;
      alu_rs2_val   <= '0;
      alu_imm       <= '0;
      alu_pc        <= '0;
      alu_pred_jump <= 1'b0;
      alu_rob_pos   <= '0;
    end else if (rdy) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (r_busy[i]) begin
          {r_q1[i], r_v1[i]} <= snoop(r_q1[i], r_v1[i], alu_result_ready, alu_result_rob_pos,
                                      alu_result_val, lsb_load_result_ready,
                                      lsb_load_result_rob_pos, lsb_load_result_val);
          {r_q2[i], r_v2[i]} <= snoop(r_q2[i], r_v2[i], alu_result_ready, alu_result_rob_pos,
                                      alu_result_val, lsb_load_result_ready,
                                      lsb_load_result_rob_pos, lsb_load_result_val);
        end
      end
      // The free slot is non-busy pre-edge, so it never collides with the wakeup writes.
      if (w_insert) begin
        r_busy[w_free_idx] <= 1'b1;
        r_op[w_free_idx]   <= issue_openum;
        r_v1[w_free_idx]   <= w_in_v1;
        r_q1[w_free_idx]   <= w_in_q1;
        r_v2[w_free_idx]   <= w_in_v2;
        r_q2[w_free_idx]   <= w_in_q2;
        r_imm[w_free_idx]  <= issue_imm;
        r_pc[w_free_idx]   <= issue_pc;
        r_pj[w_free_idx]   <= issue_pred_jump;
        r_rob[w_free_idx]  <= issue_rob_pos;
      end
      if (w_sel_found) begin
        r_busy[w_sel_idx] <= 1'b0;
        alu_enable        <= 1'b1;
        alu_openum        <= r_op[w_sel_idx];
        alu_rs1_val       <= r_v1[w_sel_idx];
        alu_rs2_val       <= r_v2[w_sel_idx];
        alu_imm           <= r_imm[w_sel_idx];
        alu_pc            <= r_pc[w_sel_idx];
        alu_pred_jump     <= r_pj[w_sel_idx];
        alu_rob_pos       <= r_rob[w_sel_idx];
      end else if (w_bypass) begin
        alu_enable    <= 1'b1;
        alu_openum    <= issue_openum;
        alu_rs1_val   <= w_in_v1;
        alu_rs2_val   <= w_in_v2;
        alu_imm       <= issue_imm;
        alu_pc        <= issue_pc;
        alu_pred_jump <= issue_pred_jump;
        alu_rob_pos   <= issue_rob_pos;
      end else begin
        alu_enable <= 1'b0;
      end
      r_count <= r_count + CNT_W'(w_insert) - CNT_W'(w_sel_found);
    end
  end
endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: expected dispatches are queued at issue time
// and a negedge monitor pops and compares them whenever alu_enable is presented.
module tb_reservation_station;
  localparam int RS_SIZE   = 16;
  localparam int ROB_POS_W = 5;
  localparam int DATA_W    = 32;
  localparam int OPENUM_W  = 6;
  localparam int EXP_W     = OPENUM_W + 4 * DATA_W + 1 + ROB_POS_W;

  logic                 clk, rst, rdy, clr, rs_enable;
  logic [OPENUM_W-1:0]  issue_openum;
  logic [DATA_W-1:0]    issue_rs1_val, issue_rs2_val, issue_imm, issue_pc;
  logic [ROB_POS_W-1:0] issue_rs1_rob_pos, issue_rs2_rob_pos, issue_rob_pos;
  logic                 issue_pred_jump;
  logic                 alu_result_ready, lsb_load_result_ready;
  logic [ROB_POS_W-1:0] alu_result_rob_pos, lsb_load_result_rob_pos;
  logic [DATA_W-1:0]    alu_result_val, lsb_load_result_val;
  logic                 rs_full, alu_enable, alu_pred_jump;
  logic [OPENUM_W-1:0]  alu_openum;
  logic [DATA_W-1:0]    alu_rs1_val, alu_rs2_val, alu_imm, alu_pc;
  logic [ROB_POS_W-1:0] alu_rob_pos;

  reservation_station #(.RS_SIZE(RS_SIZE), .ROB_POS_W(ROB_POS_W), .DATA_W(DATA_W),
                        .OPENUM_W(OPENUM_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr), .rs_enable(rs_enable),
    .issue_openum(issue_openum), .issue_rs1_val(issue_rs1_val), .issue_rs2_val(issue_rs2_val),
    .issue_rs1_rob_pos(issue_rs1_rob_pos), .issue_rs2_rob_pos(issue_rs2_rob_pos),
    .issue_imm(issue_imm), .issue_pc(issue_pc), .issue_pred_jump(issue_pred_jump),
    .issue_rob_pos(issue_rob_pos),
    .alu_result_ready(alu_result_ready), .alu_result_rob_pos(alu_result_rob_pos),
    .alu_result_val(alu_result_val),
    .lsb_load_result_ready(lsb_load_result_ready),
    .lsb_load_result_rob_pos(lsb_load_result_rob_pos),
    .lsb_load_result_val(lsb_load_result_val),
    .rs_full(rs_full), .alu_enable(alu_enable), .alu_openum(alu_openum),
    .alu_rs1_val(alu_rs1_val), .alu_rs2_val(alu_rs2_val), .alu_imm(alu_imm), .alu_pc(alu_pc),
    .alu_pred_jump(alu_pred_jump), .alu_rob_pos(alu_rob_pos)
  );

  // ---- clock ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---- scoreboard ----
  int vectors = 0;
  int miscompares = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] exp_head;
  logic             rdy_q;
  wire  [EXP_W-1:0] act_w = {alu_openum, alu_rs1_val, alu_rs2_val, alu_imm, alu_pc,
                             alu_pred_jump, alu_rob_pos};

  function automatic logic [EXP_W-1:0] pack(
    input logic [OPENUM_W-1:0] op, input logic [DATA_W-1:0] v1, input logic [DATA_W-1:0] v2,
    input logic [DATA_W-1:0] imm, input logic [DATA_W-1:0] pc, input logic pj,
    input logic [ROB_POS_W-1:0] rob);
    return {op, v1, v2, imm, pc, pj, rob};
  endfunction

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // ---- monitor ----
  always @(posedge clk) rdy_q <= rdy;

  always @(negedge clk) begin
    if (!rst && rdy_q === 1'b1 && alu_enable === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL dispatch_unexpected: got 0x%0h, want no dispatch", act_w);
      end else begin
        exp_head = exp_q.pop_front();
        if (act_w !== exp_head) begin
          miscompares++;
          $display("FAIL dispatch_payload: got 0x%0h, want 0x%0h", act_w, exp_head);
        end
      end
    end
  end

  // ---- driver tasks ----
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs_enable             = 1'b0;
    alu_result_ready      = 1'b0;
    lsb_load_result_ready = 1'b0;
    clr                   = 1'b0;
  endtask

  task automatic issue(input logic [OPENUM_W-1:0] op, input logic [DATA_W-1:0] v1,
                       input logic [ROB_POS_W-1:0] q1, input logic [DATA_W-1:0] v2,
                       input logic [ROB_POS_W-1:0] q2, input logic [DATA_W-1:0] imm,
                       input logic [DATA_W-1:0] pc, input logic pj,
                       input logic [ROB_POS_W-1:0] rob);
    rs_enable         = 1'b1;
    issue_openum      = op;
    issue_rs1_val     = v1;
    issue_rs1_rob_pos = q1;
    issue_rs2_val     = v2;
    issue_rs2_rob_pos = q2;
    issue_imm         = imm;
    issue_pc          = pc;
    issue_pred_jump   = pj;
    issue_rob_pos     = rob;
  endtask

  task automatic alu_bc(input logic [ROB_POS_W-1:0] pos, input logic [DATA_W-1:0] val);
    alu_result_ready   = 1'b1;
    alu_result_rob_pos = pos;
    alu_result_val     = val;
  endtask

  task automatic lsb_bc(input logic [ROB_POS_W-1:0] pos, input logic [DATA_W-1:0] val);
    lsb_load_result_ready   = 1'b1;
    lsb_load_result_rob_pos = pos;
    lsb_load_result_val     = val;
  endtask

  // Issue n entries whose rs1 waits on tag; when push is set, queue the post-wake payload.
  task automatic fill(input int first, input int n, input logic [ROB_POS_W-1:0] tag,
                      input logic [DATA_W-1:0] wake, input bit push);
    for (int i = first; i < first + n; i++) begin
      issue(6'd3, 32'hDEAD, tag, 32'h33, '0, DATA_W'(i), 32'h1000 + DATA_W'(4 * i),
            i[0], ROB_POS_W'(i + 1));
      if (push)
        exp_q.push_back(pack(6'd3, wake, 32'h33, DATA_W'(i), 32'h1000 + DATA_W'(4 * i),
                             i[0], ROB_POS_W'(i + 1)));
      tick();
    end
    idle();
  endtask

  // Wake all 15 stored entries with a load broadcast and expect back-to-back dispatch.
  task automatic drain(input logic [ROB_POS_W-1:0] tag, input logic [DATA_W-1:0] val);
    lsb_bc(tag, val);
    tick();
    idle();
    check("drain_wake_edge", alu_enable, 0);
    for (int k = 0; k < RS_SIZE - 1; k++) begin
      tick();
      check($sformatf("drain_en_%0d", k), alu_enable, 1);
      if (k == 0) check("drain_full_drop", rs_full, 0);
    end
    tick();
    check("drain_done", alu_enable, 0);
  endtask

  // ---- stimulus ----
  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    alu_result_rob_pos = '0;
    alu_result_val = '0;
    lsb_load_result_rob_pos = '0;
    lsb_load_result_val = '0;
    idle();
    issue(6'd1, 32'd5, '0, 32'd7, '0, '0, 32'h100, 1'b0, 5'd3);
    tick();
    tick();
    rst = 1'b0;
    idle();
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_alu_enable", alu_enable, 0);
      check("rst_payload_zero", (act_w == '0), 1);
      check("rst_rs_full", rs_full, 0);
    end

    // Ready ADD: base latency
    issue(6'd1, 32'd5, '0, 32'd7, '0, '0, 32'h100, 1'b0, 5'd3);
    exp_q.push_back(pack(6'd1, 32'd5, 32'd7, '0, 32'h100, 1'b0, 5'd3));
    tick();
    idle();
`ifdef RS_ISSUE_BYPASS_EN
    check("base_lat_en", alu_enable, 1);
`else
    check("base_lat_early", alu_enable, 0);
    tick();
    check("base_lat_en", alu_enable, 1);
`endif
    check("base_lat_rob", alu_rob_pos, 3);
    tick();
    check("base_lat_single", alu_enable, 0);

    // Pending rs1 woken by ALU broadcast two cycles later
    issue(6'd2, 32'hBAD, 5'd4, 32'h22, '0, 32'h8, 32'h200, 1'b1, 5'd5);
    exp_q.push_back(pack(6'd2, 32'h10, 32'h22, 32'h8, 32'h200, 1'b1, 5'd5));
    tick();
    idle();
    tick();
    check("wake_wait", alu_enable, 0);
    alu_bc(5'd4, 32'h10);
    tick();
    idle();
    check("wake_edge", alu_enable, 0);
    tick();
    check("wake_disp", alu_enable, 1);
    check("wake_rs1", alu_rs1_val, 32'h10);
    tick();

    // Fill 15 waiting on tag 2, then release with a load broadcast
    fill(0, 14, 5'd2, 32'd9, 1'b1);
    check("full_at_14", rs_full, 0);
    fill(14, 1, 5'd2, 32'd9, 1'b1);
    check("full_at_15", rs_full, 1);
    drain(5'd2, 32'd9);

    // Insert snoops a same-cycle load broadcast
    issue(6'd4, 32'd3, '0, 32'hBAD, 5'd6, 32'h10, 32'h300, 1'b0, 5'd7);
    lsb_bc(5'd6, 32'hAB);
    exp_q.push_back(pack(6'd4, 32'd3, 32'hAB, 32'h10, 32'h300, 1'b0, 5'd7));
    tick();
    idle();
`ifndef RS_ISSUE_BYPASS_EN
    tick();
`endif
    check("snoop_en", alu_enable, 1);
    check("snoop_rs2", alu_rs2_val, 32'hAB);
    tick();

    // Both broadcasts match the incoming tag: ALU value wins
    issue(6'd5, 32'hBAD, 5'd9, 32'd4, '0, '0, 32'h400, 1'b1, 5'd8);
    alu_bc(5'd9, 32'h55);
    lsb_bc(5'd9, 32'h66);
    exp_q.push_back(pack(6'd5, 32'h55, 32'd4, '0, 32'h400, 1'b1, 5'd8));
    tick();
    idle();
`ifndef RS_ISSUE_BYPASS_EN
    tick();
`endif
    check("snoop_alu_prio", alu_rs1_val, 32'h55);
    tick();

    // Both operands of one entry wake on the same edge
    issue(6'd6, 32'hBAD, 5'd20, 32'hBAD, 5'd21, '0, 32'h500, 1'b0, 5'd9);
    exp_q.push_back(pack(6'd6, 32'd1, 32'd2, '0, 32'h500, 1'b0, 5'd9));
    tick();
    idle();
    alu_bc(5'd20, 32'd1);
    lsb_bc(5'd21, 32'd2);
    tick();
    idle();
    check("dual_wake_edge", alu_enable, 0);
    tick();
    check("dual_wake_disp", alu_enable, 1);
    check("dual_wake_rs2", alu_rs2_val, 32'd2);
    tick();

    // rdy low: a broadcast in that cycle is ignored
    issue(6'd7, 32'hBAD, 5'd7, 32'h11, '0, '0, 32'h600, 1'b0, 5'd10);
    exp_q.push_back(pack(6'd7, 32'h78, 32'h11, '0, 32'h600, 1'b0, 5'd10));
    tick();
    idle();
    rdy = 1'b0;
    alu_bc(5'd7, 32'h77);
    tick();
    idle();
    rdy = 1'b1;
    tick();
    check("rdy_ignore_0", alu_enable, 0);
    tick();
    check("rdy_ignore_1", alu_enable, 0);
    alu_bc(5'd7, 32'h78);
    tick();
    idle();
    tick();
    check("rdy_resume", alu_enable, 1);
    check("rdy_resume_rs1", alu_rs1_val, 32'h78);

    // Flush with 5 busy entries and a simultaneous issue
    fill(15, 5, 5'd12, '0, 1'b0);
    clr = 1'b1;
    issue(6'd1, 32'd1, '0, 32'd2, '0, '0, 32'h700, 1'b0, 5'd11);
    tick();
    idle();
    check("clr_en", alu_enable, 0);
    check("clr_payload_zero", (act_w == '0), 1);
    check("clr_full", rs_full, 0);
    tick();
    check("clr_discard", alu_enable, 0);
    lsb_bc(5'd12, 32'd5);
    tick();
    idle();
    tick();
    check("clr_no_wake", alu_enable, 0);
    fill(0, 14, 5'd13, 32'hC3, 1'b1);
    check("clr_count_14", rs_full, 0);
    fill(14, 1, 5'd13, 32'hC3, 1'b1);
    check("clr_count_15", rs_full, 1);
    drain(5'd13, 32'hC3);

    repeat (4) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
